uart_frame_rx: RTL

Parametrised successor to the single-byte UART data handler. It pulls bytes from the UART RX FIFO using the WAIT_DATA / REQ_DATA / HANDLE_DATA request cycle. It assembles them into sync-prefixed, XOR-checksummed frames of configurable payload length, flags checksum and inter-byte timeout errors, and presents each good frame to the chess move logic over a valid/ready handshake.

---
 rtl/uart_frame_rx.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/uart_frame_rx.sv
// Pulls bytes from the UART RX FIFO and assembles sync-prefixed, XOR-checked frames
// for the chess move logic, flagging checksum and inter-byte timeout errors.
module uart_frame_rx #(
  parameter int unsigned       DATA_W         = 8,
  parameter int unsigned       PAYLOAD_BYTES  = 2,
  parameter logic [DATA_W-1:0] SYNC_BYTE      = 8'hA5,
  parameter int unsigned       TIMEOUT_CYCLES = 50_000_000
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            rx_empty,
  output logic                            rx_rd_en,
  input  logic [DATA_W-1:0]               rx_data,
  output logic                            msg_valid,
  input  logic                            msg_ready,
  output logic [PAYLOAD_BYTES*DATA_W-1:0] msg_payload,
  output logic                            err_crc,
  output logic                            err_timeout,
  output logic                            busy
);

  localparam int unsigned PAY_W = PAYLOAD_BYTES * DATA_W;
  localparam int unsigned IDX_W = $clog2(PAYLOAD_BYTES + 2);
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [IDX_W-1:0] IDX_CHK  = IDX_W'(PAYLOAD_BYTES + 1);
  // Firing two counts early lands the registered pulse TIMEOUT_CYCLES after the last byte.
  localparam logic [CNT_W-1:0] CNT_FIRE = CNT_W'(TIMEOUT_CYCLES - 2);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    WAIT_DATA   = 2'd0,
    REQ_DATA    = 2'd1,
    HANDLE_DATA = 2'd2,
    MSG_OUT     = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [DATA_W-1:0]  sum_q, sum_d;
  logic [PAY_W-1:0]   buf_q, buf_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PAY_W-1:0]   payload_q, payload_d;
  logic               rd_en_q, rd_en_d;
  logic               valid_q, valid_d;
  logic               err_crc_q, err_crc_d;
  logic               err_tmo_q, err_tmo_d;
  logic               busy_q, busy_d;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= WAIT_DATA;
      idx_q     <= '0;
      sum_q     <= '0;
      buf_q     <= '0;
      cnt_q     <= '0;
      payload_q <= '0;
      rd_en_q   <= 1'b0;
      valid_q   <= 1'b0;
      err_crc_q <= 1'b0;
      err_tmo_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      sum_q     <= sum_d;
      buf_q     <= buf_d;
      cnt_q     <= cnt_d;
      payload_q <= payload_d;
      rd_en_q   <= rd_en_d;
      valid_q   <= valid_d;
      err_crc_q <= err_crc_d;
      err_tmo_q <= err_tmo_d;
      busy_q    <= busy_d;
    end
  end

  // Next state, frame assembly and timeout tracking
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    sum_d     = sum_q;
    buf_d     = buf_q;
    cnt_d     = cnt_q;
    payload_d = payload_q;
    err_crc_d = 1'b0;
    err_tmo_d = 1'b0;

    if (idx_q == '0) begin
      cnt_d = '0;
    end

    case (state_q)
      WAIT_DATA: begin
        // Timeout takes priority over a byte arriving in the same cycle.
        if ((idx_q != '0) && (cnt_q == CNT_FIRE)) begin
          err_tmo_d = 1'b1;
          idx_d     = '0;
          cnt_d     = '0;
        end else begin
          if ((idx_q != '0) && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
          if (!rx_empty) begin
            state_d = REQ_DATA;
          end
        end
      end

      REQ_DATA: begin
        state_d = HANDLE_DATA;
      end

      HANDLE_DATA: begin
        cnt_d   = '0;
        state_d = rx_empty ? WAIT_DATA : REQ_DATA;
        if (idx_q == '0) begin
          if (rx_data == SYNC_BYTE) begin
            idx_d = IDX_W'(1);
            sum_d = '0;
          end
        end else if (idx_q == IDX_CHK) begin
          idx_d = '0;
          if (rx_data == sum_q) begin
            state_d   = MSG_OUT;
            payload_d = buf_q;
          end else begin
            err_crc_d = 1'b1;
            state_d   = WAIT_DATA;
          end
        end else begin
          sum_d = sum_q ^ rx_data;
          idx_d = idx_q + IDX_W'(1);
          for (int unsigned k = 0; k < PAYLOAD_BYTES; k++) begin
            if (idx_q == IDX_W'(k + 1)) begin
              buf_d[k*DATA_W +: DATA_W] = rx_data;
            end
          end
        end
      end

      MSG_OUT: begin
        if (msg_ready) begin
          state_d = WAIT_DATA;
        end
      end

      default: begin
        state_d = WAIT_DATA;
      end
    endcase
  end

  // Registered outputs decoded from the upcoming state
  always_comb begin
    rd_en_d = 1'b0;
    valid_d = 1'b0;
    busy_d  = 1'b0;
    if (state_d == REQ_DATA) begin
      rd_en_d = 1'b1;
    end
    if (state_d == MSG_OUT) begin
      valid_d = 1'b1;
    end
    if ((idx_d != '0) || (state_d == MSG_OUT)) begin
      busy_d = 1'b1;
    end
  end

  assign rx_rd_en    = rd_en_q;
  assign msg_valid   = valid_q;
  assign msg_payload = payload_q;
  assign err_crc     = err_crc_q;
  assign err_timeout = err_tmo_q;
  assign busy        = busy_q;

endmodule
